// File: rtl/clock_timekeeper.sv
// Time-of-day BCD counter (hh:mm:ss) with RUN/SET control; optional 12-hour mode via `TIMEKEEPER_12H_EN.
// Latency: every output is registered, so an input sampled at edge N shows up after edge N.
// Backpressure: none. Strobes and button pulses are single-cycle events that are either consumed or ignored.
module clock_timekeeper #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       strobe_in,
    input  logic       set_toggle,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [1:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       setting,
    output logic       minute_tick,
    output logic       day_tick,
    output logic       pm
);

    localparam int PW = $clog2(TICKS_PER_SEC) + 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

`ifdef TIMEKEEPER_12H_EN
    localparam logic [1:0] HT_RST = 2'd1;
    localparam logic [3:0] HO_RST = 4'd2;
`else
    localparam logic [1:0] HT_RST = 2'd0;
    localparam logic [3:0] HO_RST = 4'd0;
`endif

    typedef enum logic {ST_RUN, ST_SET} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [1:0]      hour_tens_q, hour_tens_d;
    logic [3:0]      hour_ones_q, hour_ones_d;
    logic [2:0]      min_tens_q, min_tens_d;
    logic [3:0]      min_ones_q, min_ones_d;
    logic [2:0]      sec_tens_q, sec_tens_d;
    logic [3:0]      sec_ones_q, sec_ones_d;
    logic            minute_tick_q, minute_tick_d;
    logic            day_tick_q, day_tick_d;
`ifdef TIMEKEEPER_12H_EN
    logic            pm_q, pm_d;
`endif

    // Incremented candidates for each field; shared by the seconds ripple and SET-mode buttons.
    logic [2:0] sec_inc_t;
    logic [3:0] sec_inc_o;
    logic       sec_wrap;
    logic [2:0] min_inc_t;
    logic [3:0] min_inc_o;
    logic       min_wrap;
    logic [1:0] hr_inc_t;
    logic [3:0] hr_inc_o;
    logic       hr_roll;   // 24h: 23 -> 00 ; 12h: 11 -> 12 (the pm flip point)

    // Seconds +1 modulo 60, flagging the wrap.
    always_comb begin
        sec_inc_t = sec_tens_q;
        sec_inc_o = sec_ones_q + 4'd1;
        sec_wrap  = 1'b0;
        if (sec_ones_q == 4'd9) begin
            sec_inc_o = 4'd0;
            if (sec_tens_q == 3'd5) begin
                sec_inc_t = 3'd0;
                sec_wrap  = 1'b1;
            end else begin
                sec_inc_t = sec_tens_q + 3'd1;
            end
        end
    end

    // Minutes +1 modulo 60, flagging the wrap.
    always_comb begin
        min_inc_t = min_tens_q;
        min_inc_o = min_ones_q + 4'd1;
        min_wrap  = 1'b0;
        if (min_ones_q == 4'd9) begin
            min_inc_o = 4'd0;
            if (min_tens_q == 3'd5) begin
                min_inc_t = 3'd0;
                min_wrap  = 1'b1;
            end else begin
                min_inc_t = min_tens_q + 3'd1;
            end
        end
    end

    // Hours +1 in the selected hour format.
    always_comb begin
        hr_inc_t = hour_tens_q;
        hr_inc_o = hour_ones_q + 4'd1;
        hr_roll  = 1'b0;
`ifdef TIMEKEEPER_12H_EN
        if (hour_tens_q == 2'd1 && hour_ones_q == 4'd1) begin
            hr_inc_t = 2'd1;
            hr_inc_o = 4'd2;
            hr_roll  = 1'b1;
        end else if (hour_tens_q == 2'd1 && hour_ones_q == 4'd2) begin
            hr_inc_t = 2'd0;
            hr_inc_o = 4'd1;
        end else if (hour_ones_q == 4'd9) begin
            hr_inc_t = 2'd1;
            hr_inc_o = 4'd0;
        end
`else
        if (hour_tens_q == 2'd2 && hour_ones_q == 4'd3) begin
            hr_inc_t = 2'd0;
            hr_inc_o = 4'd0;
            hr_roll  = 1'b1;
        end else if (hour_ones_q == 4'd9) begin
            hr_inc_t = hour_tens_q + 2'd1;
            hr_inc_o = 4'd0;
        end
`endif
    end

    // Next-state logic: RUN/SET control, prescaler, second-advance ripple and SET-mode edits.
    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        hour_tens_d   = hour_tens_q;
        hour_ones_d   = hour_ones_q;
        min_tens_d    = min_tens_q;
        min_ones_d    = min_ones_q;
        sec_tens_d    = sec_tens_q;
        sec_ones_d    = sec_ones_q;
        minute_tick_d = 1'b0;
        day_tick_d    = 1'b0;
`ifdef TIMEKEEPER_12H_EN
        pm_d          = pm_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (set_toggle) begin
                    // Toggle wins over everything; only the seconds clear happens this cycle.
                    state_d    = ST_SET;
                    presc_d    = '0;
                    sec_tens_d = 3'd0;
                    sec_ones_d = 4'd0;
                end else if (strobe_in) begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d    = '0;
                        sec_tens_d = sec_inc_t;
                        sec_ones_d = sec_inc_o;
                        if (sec_wrap) begin
                            minute_tick_d = 1'b1;
                            min_tens_d    = min_inc_t;
                            min_ones_d    = min_inc_o;
                            if (min_wrap) begin
                                hour_tens_d = hr_inc_t;
                                hour_ones_d = hr_inc_o;
                                if (hr_roll) begin
`ifdef TIMEKEEPER_12H_EN
                                    pm_d       = ~pm_q;
                                    day_tick_d = pm_q;
`else
                                    day_tick_d = 1'b1;
`endif
                                end
                            end
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            ST_SET: begin
                if (set_toggle) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end else begin
                    // Minutes and hours edit independently; no carry between them.
                    if (inc_min) begin
                        min_tens_d = min_inc_t;
                        min_ones_d = min_inc_o;
                    end
                    if (inc_hour) begin
                        hour_tens_d = hr_inc_t;
                        hour_ones_d = hr_inc_o;
`ifdef TIMEKEEPER_12H_EN
                        if (hr_roll) begin
                            pm_d = ~pm_q;
                        end
`endif
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and time registers with asynchronous reset.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            presc_q       <= '0;
            hour_tens_q   <= HT_RST;
            hour_ones_q   <= HO_RST;
            min_tens_q    <= 3'd0;
            min_ones_q    <= 4'd0;
            sec_tens_q    <= 3'd0;
            sec_ones_q    <= 4'd0;
            minute_tick_q <= 1'b0;
            day_tick_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            hour_tens_q   <= hour_tens_d;
            hour_ones_q   <= hour_ones_d;
            min_tens_q    <= min_tens_d;
            min_ones_q    <= min_ones_d;
            sec_tens_q    <= sec_tens_d;
            sec_ones_q    <= sec_ones_d;
            minute_tick_q <= minute_tick_d;
            day_tick_q    <= day_tick_d;
        end
    end

`ifdef TIMEKEEPER_12H_EN
    // PM flag register, only present in 12-hour mode.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pm_q <= 1'b0;
        end else begin
            pm_q <= pm_d;
        end
    end

    assign pm = pm_q;
`else
    assign pm = 1'b0;
`endif

    assign hour_tens   = hour_tens_q;
    assign hour_ones   = hour_ones_q;
    assign min_tens    = min_tens_q;
    assign min_ones    = min_ones_q;
    assign sec_tens    = sec_tens_q;
    assign sec_ones    = sec_ones_q;
    assign setting     = (state_q == ST_SET);
    assign minute_tick = minute_tick_q;
    assign day_tick    = day_tick_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Bench for clock_timekeeper: table vectors, directed corner sequences, random stimulus vs a seconds-of-day model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_clock_timekeeper;

    localparam int TPS = 4;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       strobe_in, set_toggle, inc_min, inc_hour;
    logic [1:0] hour_tens;
    logic [3:0] hour_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       setting, minute_tick, day_tick, pm;

    clock_timekeeper #(.TICKS_PER_SEC(TPS)) dut (
        .clk_in(clk_in), .reset(reset), .strobe_in(strobe_in), .set_toggle(set_toggle),
        .inc_min(inc_min), .inc_hour(inc_hour), .hour_tens(hour_tens), .hour_ones(hour_ones),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .setting(setting), .minute_tick(minute_tick), .day_tick(day_tick), .pm(pm)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Reference model: time as seconds since midnight, plus mode and strobe count.
    int m_t, m_presc;
    bit m_set, m_mt, m_dt;

    function automatic logic [5:0] hr_disp(input int h24);
        int h;
`ifdef TIMEKEEPER_12H_EN
        h = h24 % 12;
        if (h == 0) h = 12;
`else
        h = h24;
`endif
        return {2'(h / 10), 4'(h % 10)};
    endfunction

    function automatic logic [23:0] model_vec();
        int h, mn, s;
        bit p;
        h  = m_t / 3600;
        mn = (m_t / 60) % 60;
        s  = m_t % 60;
`ifdef TIMEKEEPER_12H_EN
        p = (h >= 12);
`else
        p = 1'b0;
`endif
        return {hr_disp(h), 3'(mn / 10), 4'(mn % 10), 3'(s / 10), 4'(s % 10), m_set, m_mt, m_dt, p};
    endfunction

    function automatic logic [23:0] dut_vec();
        return {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones,
                setting, minute_tick, day_tick, pm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_presc = 0; m_set = 0; m_mt = 0; m_dt = 0;
    endtask

    task automatic model_step(input bit st, input bit sb, input bit im, input bit ih);
        int h, mn;
        m_mt = 0;
        m_dt = 0;
        if (!m_set) begin
            if (st) begin
                m_set   = 1;
                m_t     = m_t - (m_t % 60);
                m_presc = 0;
            end else if (sb) begin
                m_presc++;
                if (m_presc == TPS) begin
                    m_presc = 0;
                    m_t  = (m_t + 1) % 86400;
                    m_mt = (m_t % 60 == 0);
                    m_dt = (m_t == 0);
                end
            end
        end else begin
            if (st) begin
                m_set   = 0;
                m_presc = 0;
            end else begin
                h  = m_t / 3600;
                mn = (m_t / 60) % 60;
                if (im) mn = (mn + 1) % 60;
                if (ih) h = (h + 1) % 24;
                m_t = h * 3600 + mn * 60 + (m_t % 60);
            end
        end
    endtask

    // One clock cycle with the given inputs; compares the whole output vector to the model.
    task automatic cyc(input bit st, input bit sb, input bit im, input bit ih);
        set_toggle = st; strobe_in = sb; inc_min = im; inc_hour = ih;
        @(posedge clk_in);
        #1;
        model_step(st, sb, im, ih);
        check("model", 32'(dut_vec()), 32'(model_vec()));
        set_toggle = 0; strobe_in = 0; inc_min = 0; inc_hour = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset = 1;
        model_reset();
        @(negedge clk_in);
        reset = 0;
    endtask

    task automatic repeat_cyc(input int n, input bit st, input bit sb, input bit im, input bit ih);
        for (int i = 0; i < n; i++) cyc(st, sb, im, ih);
    endtask

    typedef struct {
        bit         st, sb, im, ih;
        logic [6:0] e_min;
        logic [6:0] e_sec;
        bit         e_set;
        bit         e_mt;
    } vec_t;

    vec_t tbl[14];
    int   mt_count;

    initial begin
        tbl[0]  = '{0, 1, 0, 0, 7'h00, 7'h00, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 7'h00, 7'h00, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 7'h00, 7'h00, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 7'h00, 7'h01, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 7'h00, 7'h01, 0, 0};
        tbl[5]  = '{1, 1, 0, 0, 7'h00, 7'h00, 1, 0};
        tbl[6]  = '{0, 1, 0, 0, 7'h00, 7'h00, 1, 0};
        tbl[7]  = '{0, 0, 1, 0, 7'h01, 7'h00, 1, 0};
        tbl[8]  = '{0, 1, 1, 0, 7'h02, 7'h00, 1, 0};
        tbl[9]  = '{1, 0, 0, 0, 7'h02, 7'h00, 0, 0};
        tbl[10] = '{0, 1, 0, 0, 7'h02, 7'h00, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 7'h02, 7'h00, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 7'h02, 7'h00, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 7'h02, 7'h01, 0, 0};

        reset = 1; strobe_in = 0; set_toggle = 0; inc_min = 0; inc_hour = 0;
        model_reset();
        #12;
        reset = 0;

        // Asynchronous reset in the middle of a count, checked before any edge.
        cyc(1, 0, 0, 0);
        repeat_cyc(3, 0, 0, 1, 0);
        repeat_cyc(2, 0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        repeat_cyc(6, 0, 1, 0, 0);
        #2;
        reset = 1;
        model_reset();
        #1;
        check("reset_async", 32'(dut_vec()), 32'(model_vec()));
        check("reset_hour", 32'({hour_tens, hour_ones}), 32'(hr_disp(0)));
        @(negedge clk_in);
        reset = 0;

        // Table vectors from reset.
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].st, tbl[i].sb, tbl[i].im, tbl[i].ih);
            check($sformatf("tbl%0d", i),
                  32'({min_tens, min_ones, sec_tens, sec_ones, setting, minute_tick}),
                  32'({tbl[i].e_min, tbl[i].e_sec, tbl[i].e_set, tbl[i].e_mt}));
        end

        // 240 strobes from reset -> 00:01:00 with a single minute_tick right after the last strobe.
        do_reset();
        mt_count = 0;
        for (int i = 0; i < 240; i++) begin
            cyc(0, 1, 0, 0);
            if (minute_tick) mt_count++;
        end
        check("ripple_mtick_last", 32'(minute_tick), 32'd1);
        check("ripple_mtick_cnt", 32'(mt_count), 32'd1);
        check("ripple_time", 32'({hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones}),
              32'({hr_disp(0), 7'h01, 7'h00}));

        // Day wrap from 23:59 set by hand.
        do_reset();
        cyc(1, 0, 0, 0);
        repeat_cyc(23, 0, 0, 0, 1);
        repeat_cyc(59, 0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        check("daywrap_set", 32'({hour_tens, hour_ones, min_tens, min_ones, setting}),
              32'({hr_disp(23), 7'h59, 1'b0}));
        repeat_cyc(239, 0, 1, 0, 0);
        check("daywrap_pre", 32'({minute_tick, day_tick}), 32'd0);
        cyc(0, 1, 0, 0);
        check("daywrap_ticks", 32'({minute_tick, day_tick, pm}), 32'b110);
        check("daywrap_time", 32'({hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones}),
              32'({hr_disp(0), 7'h00, 7'h00}));

        // SET mode from 10:20:37, toggle together with a strobe.
        do_reset();
        cyc(1, 0, 0, 0);
        repeat_cyc(10, 0, 0, 0, 1);
        repeat_cyc(20, 0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        repeat_cyc(37 * TPS, 0, 1, 0, 0);
        check("set_pre", 32'({hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones}),
              32'({hr_disp(10), 7'h20, 7'h37}));
        cyc(1, 1, 0, 0);
        check("set_entry", 32'({hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones, setting}),
              32'({hr_disp(10), 7'h20, 7'h00, 1'b1}));
        repeat_cyc(45, 0, 0, 1, 0);
        check("set_45min", 32'({hour_tens, hour_ones, min_tens, min_ones}), 32'({hr_disp(10), 7'h05}));
        repeat_cyc(8, 0, 1, 0, 0);
        check("set_strobe_ign", 32'({hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones}),
              32'({hr_disp(10), 7'h05, 7'h00}));

        // Both increments together at 23:59 in SET -> 00:00.
        repeat_cyc(13, 0, 0, 0, 1);
        repeat_cyc(54, 0, 0, 1, 0);
        check("both_pre", 32'({hour_tens, hour_ones, min_tens, min_ones}), 32'({hr_disp(23), 7'h59}));
        cyc(0, 0, 1, 1);
        check("both_inc", 32'({hour_tens, hour_ones, min_tens, min_ones, pm}), 32'({hr_disp(0), 7'h00, 1'b0}));
        cyc(1, 0, 0, 0);

`ifdef TIMEKEEPER_12H_EN
        // 12-hour mode: 11:59:59 -> 12:00:00 PM without day_tick, then the next wrap back to AM.
        do_reset();
        cyc(1, 0, 0, 0);
        repeat_cyc(11, 0, 0, 0, 1);
        repeat_cyc(59, 0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        repeat_cyc(59 * TPS, 0, 1, 0, 0);
        check("h12_pre", 32'({hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones, pm}),
              32'({6'h11, 7'h59, 7'h59, 1'b0}));
        repeat_cyc(TPS, 0, 1, 0, 0);
        check("h12_noon", 32'({hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones, pm, day_tick}),
              32'({6'h12, 7'h00, 7'h00, 1'b1, 1'b0}));
        cyc(1, 0, 0, 0);
        repeat_cyc(11, 0, 0, 0, 1);
        repeat_cyc(59, 0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        repeat_cyc(60 * TPS, 0, 1, 0, 0);
        check("h12_midnight", 32'({hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones, pm, day_tick}),
              32'({6'h12, 7'h00, 7'h00, 1'b0, 1'b1}));
`endif

        // Random stimulus against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
